// File: rtl/switch_conditioner.sv
// switch_conditioner: synchronise, debounce and edge-detect a raw push-button.
// Also raises a one-cycle long-press strobe and a held-long level.
//
// Ports:
//   i_Clk         system clock, all logic on posedge
//   i_Reset       synchronous active-high reset
//   i_Switch      raw asynchronous button pin
//   o_Switch      debounced level, same polarity as the pin
//   o_Press       1-cycle strobe when o_Switch becomes PRESS_LEVEL
//   o_Release     1-cycle strobe when o_Switch leaves PRESS_LEVEL
//   o_Long_Press  1-cycle strobe after LONG_PRESS_LIMIT held cycles
//   o_Held_Long   level, set with o_Long_Press, cleared with o_Release
module switch_conditioner #(
    parameter int   DEBOUNCE_LIMIT   = 250000,
    parameter int   LONG_PRESS_LIMIT = 25000000,
    parameter logic PRESS_LEVEL      = 1'b1
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_Switch,
    output logic o_Switch,
    output logic o_Press,
    output logic o_Release,
    output logic o_Long_Press,
    output logic o_Held_Long
);

    localparam int DB_W   = $clog2(DEBOUNCE_LIMIT + 1);
    localparam int HOLD_W = $clog2(LONG_PRESS_LIMIT + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_LIMIT - 1);
    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_LIMIT);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_LIMIT - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              level_q, level_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              long_q, long_d;
    logic              held_q, held_d;
    logic              accept;
    logic              pressed;

    always_comb begin
        sync1_d   = i_Switch;
        sync2_d   = sync1_q;
        level_d   = level_q;
        db_cnt_d  = '0;
        hold_d    = hold_q;
        held_d    = held_q;
        accept    = 1'b0;
        pressed   = (level_q == PRESS_LEVEL);

        // Any cycle where the synced pin agrees with the level restarts the count.
        if (sync2_q != level_q) begin
            if (db_cnt_q == DB_LAST) begin
                level_d = sync2_q;
                accept  = 1'b1;
            end else begin
                db_cnt_d = db_cnt_q + DB_ONE;
            end
        end

        // Strobes are registered alongside the level so they line up with it.
        press_d   = accept && (sync2_q == PRESS_LEVEL);
        release_d = accept && (sync2_q != PRESS_LEVEL);

        if (!pressed) begin
            hold_d = '0;
        end else if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + HOLD_ONE;
        end

        // Saturation makes HOLD_LAST reachable only once per press.
        // A long press landing on the release edge is dropped.
        long_d = pressed && (hold_q == HOLD_LAST) && !release_d;

        if (release_d || !pressed) begin
            held_d = 1'b0;
        end else if (long_d) begin
            held_d = 1'b1;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            sync1_q   <= ~PRESS_LEVEL;
            sync2_q   <= ~PRESS_LEVEL;
            level_q   <= ~PRESS_LEVEL;
            db_cnt_q  <= '0;
            hold_q    <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            level_q   <= level_d;
            db_cnt_q  <= db_cnt_d;
            hold_q    <= hold_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            held_q    <= held_d;
        end
    end

    assign o_Switch     = level_q;
    assign o_Press      = press_q;
    assign o_Release    = release_q;
    assign o_Long_Press = long_q;
    assign o_Held_Long  = held_q;

endmodule

// File: tb/tb_switch_conditioner.sv
// tb_switch_conditioner: directed and random checks of switch_conditioner
// against a windowed reference model of the debounce and hold rules.
module tb_switch_conditioner;

    localparam int DL = 8;
    localparam int LP = 20;

    logic i_Clk = 1'b0;
    logic i_Reset = 1'b1;
    logic i_Switch = 1'b0;
    logic o_Switch, o_Press, o_Release, o_Long_Press, o_Held_Long;

    switch_conditioner #(
        .DEBOUNCE_LIMIT(DL),
        .LONG_PRESS_LIMIT(LP),
        .PRESS_LEVEL(1'b1)
    ) dut (
        .i_Clk(i_Clk),
        .i_Reset(i_Reset),
        .i_Switch(i_Switch),
        .o_Switch(o_Switch),
        .o_Press(o_Press),
        .o_Release(o_Release),
        .o_Long_Press(o_Long_Press),
        .o_Held_Long(o_Held_Long)
    );

    always #5 i_Clk = ~i_Clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_press = 0, n_rel = 0, n_long = 0;
    int press_cyc = -1, rel_cyc = -1, long_cyc = -1;

    // Reference model: the debouncer sees the pin two edges late; the level
    // flips once the last DL values it saw all disagree with the level.
    bit m_lvl;
    bit m_dly[$];
    bit m_win[$];
    int m_age;
    bit e_press, e_rel, e_long, e_held;

    task automatic model_edge(input bit pin, input bit rst);
        bit seen;
        bit flip;
        e_press = 1'b0;
        e_rel   = 1'b0;
        e_long  = 1'b0;
        if (rst) begin
            m_lvl = 1'b0;
            m_dly = '{1'b0, 1'b0};
            m_win.delete();
            m_age = 0;
        end else begin
            seen = m_dly.pop_front();
            m_dly.push_back(pin);
            m_win.push_back(seen);
            if (m_win.size() > DL) void'(m_win.pop_front());
            flip = (m_win.size() == DL);
            foreach (m_win[i]) if (m_win[i] == m_lvl) flip = 1'b0;
            if (flip) begin
                m_lvl = !m_lvl;
                m_win.delete();
                if (m_lvl) begin
                    e_press = 1'b1;
                    m_age = 0;
                end else begin
                    e_rel = 1'b1;
                end
            end else if (m_lvl) begin
                m_age++;
                if (m_age == LP) e_long = 1'b1;
            end
        end
        e_held = m_lvl && (m_age >= LP);
    endtask

    task automatic check_bit(input string tag, input logic got, input logic exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input bit pin, input bit rst);
        i_Switch = pin;
        i_Reset  = rst;
        @(posedge i_Clk);
        cyc++;
        model_edge(pin, rst);
        #1;
        check_bit("switch", o_Switch, m_lvl);
        check_bit("press", o_Press, e_press);
        check_bit("release", o_Release, e_rel);
        check_bit("long", o_Long_Press, e_long);
        check_bit("held", o_Held_Long, e_held);
        if (o_Press === 1'b1) begin n_press++; press_cyc = cyc; end
        if (o_Release === 1'b1) begin n_rel++; rel_cyc = cyc; end
        if (o_Long_Press === 1'b1) begin n_long++; long_cyc = cyc; end
    endtask

    task automatic run(input bit pin, input int n);
        for (int i = 0; i < n; i++) step(pin, 1'b0);
    endtask

    initial begin
        int e0;
        int base;
        int len;
        bit pin;

        // Reset with the pin high: everything idle.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        run(1'b0, 12);
        check_int("idle_press_cnt", n_press, 0);

        // Clean press held 40 cycles.
        e0 = cyc + 1;
        run(1'b1, 40);
        check_int("press_cnt", n_press, 1);
        check_int("press_lat", press_cyc - e0, DL + 1);
        check_int("long_cnt", n_long, 1);
        check_int("long_lat", long_cyc - press_cyc, LP);
        check_bit("held_after_long", o_Held_Long, 1'b1);
        e0 = cyc + 1;
        run(1'b0, 12);
        check_int("rel_lat_long", rel_cyc - e0, DL + 1);
        check_bit("held_clr", o_Held_Long, 1'b0);

        // Bounce: never long enough to be accepted.
        base = n_press;
        run(1'b1, 7);
        run(1'b0, 1);
        run(1'b1, 7);
        run(1'b0, 12);
        check_int("bounce_press", n_press, base);
        check_bit("bounce_level", o_Switch, 1'b0);

        // Short press released after 10 held cycles.
        base = n_long;
        for (int i = 0; i < 40 && n_press == 1; i++) step(1'b1, 1'b0);
        run(1'b1, 10);
        e0 = cyc + 1;
        run(1'b0, 12);
        check_int("short_rel_lat", rel_cyc - e0, DL + 1);
        check_int("short_no_long", n_long, base);

        // Long hold: one long strobe only, held clears on release.
        base = n_long;
        run(1'b1, 70);
        check_int("single_long", n_long - base, 1);
        run(1'b0, 12);
        check_bit("held_after_rel", o_Held_Long, 1'b0);

        // Reset mid-hold with the pin still high.
        base = n_press;
        for (int i = 0; i < 40 && n_press == base; i++) step(1'b1, 1'b0);
        run(1'b1, 15);
        base = n_rel;
        step(1'b1, 1'b1);
        check_bit("rst_idle", o_Switch, 1'b0);
        e0 = cyc;
        run(1'b1, 12);
        check_int("rst_no_rel", n_rel, base);
        check_int("rst_repress_lat", press_cyc - e0, DL + 2);
        run(1'b0, 12);

        // Random runs, occasional long holds and resets.
        for (int s = 0; s < 250; s++) begin
            pin = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 5) == 0) ? int'($urandom_range(20, 35))
                                              : int'($urandom_range(1, 12));
            if ($urandom_range(0, 39) == 0) step(pin, 1'b1);
            run(pin, len);
        end
        run(1'b0, 12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
